// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle control sequencer for the 16-bit CPU datapath.
// Each instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The block
// drives the datapath select lines, the register/memory/PC enables, and
// counts retired instructions.
//
// Control outputs are decoded from the state register plus the opcode that
// was captured at the end of DECODE. Three outputs also look at a live input
// in the same cycle: ir_write (imem_ready), the BEQ branch select (alu_zero)
// and STORE retirement in MEM (dmem_ready).
module cpu_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        alu_zero,
  output logic        imem_req,
  output logic        ir_write,
  output logic        alu_src,
  output logic [1:0]  pc_src,
  output logic [1:0]  wb_sel,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_write,
  output logic        illegal_op,
  output logic        halted,
  output logic [15:0] instret
);

  // Opcode map (instr[15:12]); 0x8..0xE are undefined.
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ALUI  = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_JAL   = 4'h5;
  localparam logic [3:0] OP_JALR  = 4'h6;
  localparam logic [3:0] OP_LUI   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Next-PC select encodings.
  localparam logic [1:0] PC_PLUS2 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  // Write-back select encodings.
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC2  = 2'd2;
  localparam logic [1:0] WB_LUI  = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state_reg;
  logic [3:0]  op_reg;
  logic [15:0] instret_reg;

  // Only the opcode field matters to the sequencer; operand fields go
  // straight to the datapath.
  logic [3:0] dec_op;
  logic       instr_unused;
  assign dec_op       = instr[15:12];
  assign instr_unused = ^instr[11:0];

  logic dec_illegal;
  logic dec_halt;
  assign dec_illegal = (dec_op >= 4'h8) && (dec_op <= 4'hE);
  assign dec_halt    = (dec_op == OP_HALT);

  // Opcode class flags from the captured opcode (valid EXEC onward).
  logic op_load;
  logic op_store;
  logic op_beq;
  logic op_jal;
  logic op_jalr;
  assign op_load  = (op_reg == OP_LOAD);
  assign op_store = (op_reg == OP_STORE);
  assign op_beq   = (op_reg == OP_BEQ);
  assign op_jal   = (op_reg == OP_JAL);
  assign op_jalr  = (op_reg == OP_JALR);

  // Per-opcode operand-B and write-back selects, held EXEC through the end.
  logic       sel_alu_src;
  logic [1:0] sel_wb;
  always_comb begin
    sel_alu_src = 1'b0;
    sel_wb      = WB_ALU;
    case (op_reg)
      OP_RTYPE: begin sel_alu_src = 1'b0; sel_wb = WB_ALU; end
      OP_ALUI:  begin sel_alu_src = 1'b1; sel_wb = WB_ALU; end
      OP_LOAD:  begin sel_alu_src = 1'b1; sel_wb = WB_MEM; end
      OP_STORE: begin sel_alu_src = 1'b1; sel_wb = WB_ALU; end
      OP_BEQ:   begin sel_alu_src = 1'b0; sel_wb = WB_ALU; end
      OP_JAL:   begin sel_alu_src = 1'b0; sel_wb = WB_PC2; end
      OP_JALR:  begin sel_alu_src = 1'b1; sel_wb = WB_PC2; end
      OP_LUI:   begin sel_alu_src = 1'b0; sel_wb = WB_LUI; end
      default:  begin sel_alu_src = 1'b0; sel_wb = WB_ALU; end
    endcase
  end

  // Retiring cycle: exactly one per instruction, drives pc_write and instret.
  logic retire;
  always_comb begin
    retire = 1'b0;
    case (state_reg)
      S_DECODE: retire = dec_illegal;
      S_EXEC:   retire = op_beq;
      S_MEM:    retire = op_store && dmem_ready;
      S_WB:     retire = 1'b1;
      default:  retire = 1'b0;
    endcase
  end

  // Output decode from state and captured opcode; zero unless asserted below.
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    alu_src    = 1'b0;
    pc_src     = PC_PLUS2;
    wb_sel     = WB_ALU;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    illegal_op = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      S_DECODE: begin
        // Undefined opcodes skip to the next instruction with PC+2.
        illegal_op = dec_illegal;
      end
      S_EXEC: begin
        alu_src = sel_alu_src;
        wb_sel  = sel_wb;
        if (op_beq) begin
          pc_src = alu_zero ? PC_IMM : PC_PLUS2;
        end
      end
      S_MEM: begin
        alu_src   = sel_alu_src;
        wb_sel    = sel_wb;
        mem_read  = op_load;
        mem_write = op_store;
      end
      S_WB: begin
        alu_src   = sel_alu_src;
        wb_sel    = sel_wb;
        reg_write = 1'b1;
        // Jumps redirect the PC in the same cycle PC+2 is written back.
        if (op_jal) begin
          pc_src = PC_IMM;
        end else if (op_jalr) begin
          pc_src = PC_ALU;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  assign pc_write = retire;
  assign instret  = instret_reg;

  // Sequencer state, captured opcode and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      op_reg      <= 4'h0;
      instret_reg <= 16'h0000;
    end else begin
      if (retire) begin
        instret_reg <= instret_reg + 16'd1;
      end
      case (state_reg)
        S_FETCH: begin
          if (imem_ready) begin
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          op_reg <= dec_op;
          if (dec_halt) begin
            state_reg <= S_HALT;
          end else if (dec_illegal) begin
            state_reg <= S_FETCH;
          end else begin
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_load || op_store) begin
            state_reg <= S_MEM;
          end else if (op_beq) begin
            state_reg <= S_FETCH;
          end else begin
            state_reg <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            state_reg <= op_load ? S_WB : S_FETCH;
          end
        end
        S_WB: begin
          state_reg <= S_FETCH;
        end
        S_HALT: begin
          state_reg <= S_HALT;
        end
        default: begin
          state_reg <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: directed scenarios followed by a randomized
// instruction stream. A per-instruction reference model expands each
// instruction into its expected cycle-by-cycle output sequence.
module tb_cpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic        imem_req;
  logic        ir_write;
  logic        alu_src;
  logic [1:0]  pc_src;
  logic [1:0]  wb_sel;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        pc_write;
  logic        illegal_op;
  logic        halted;
  logic [15:0] instret;

  cpu_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .alu_zero   (alu_zero),
    .imem_req   (imem_req),
    .ir_write   (ir_write),
    .alu_src    (alu_src),
    .pc_src     (pc_src),
    .wb_sel     (wb_sel),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .pc_write   (pc_write),
    .illegal_op (illegal_op),
    .halted     (halted),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req;
    logic       irw;
    logic       as;
    logic [1:0] pcs;
    logic [1:0] wbs;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       pw;
    logic       ill;
    logic       hlt;
  } exp_t;

  int          checks = 0;
  int          passed = 0;
  logic [15:0] model_instret = 16'h0000;
  logic [15:0] cur_instr = 16'h0000;

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] rw16();
    return 16'($urandom());
  endfunction

  // Drive one cycle of inputs, compare all outputs mid-cycle, advance.
  task automatic cycle(input logic ir, input logic dr, input logic az,
                       input logic [15:0] ins, input exp_t e, input string tag);
    logic [28:0] obs;
    logic [28:0] expv;
    imem_ready = ir;
    dmem_ready = dr;
    alu_zero   = az;
    instr      = ins;
    @(negedge clk);
    obs  = {imem_req, ir_write, alu_src, pc_src, wb_sel, reg_write,
            mem_read, mem_write, pc_write, illegal_op, halted, instret};
    expv = {e, model_instret};
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s instr=%h observed=%h expected=%h", tag, cur_instr, obs, expv);
    @(posedge clk);
    #1;
    if (rst) model_instret = 16'h0000;
    else if (e.pw) model_instret = model_instret + 16'd1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_instret = 16'h0000;
  endtask

  // Reference model: expands one instruction into its expected cycles.
  // iw/dw are memory wait cycles; abort asserts rst in the last MEM wait.
  task automatic run_instr(input logic [15:0] ins, input int iw, input int dw,
                           input logic az, input bit abort);
    logic [3:0] op;
    logic       as;
    logic [1:0] ws;
    logic [1:0] final_pcs;
    bit         is_mem;
    exp_t       e;
    op = ins[15:12];
    cur_instr = ins;
    as = 1'b0; ws = 2'd0; final_pcs = 2'd0;
    case (op)
      4'h1: as = 1'b1;
      4'h2: begin as = 1'b1; ws = 2'd1; end
      4'h3: as = 1'b1;
      4'h5: begin ws = 2'd2; final_pcs = 2'd1; end
      4'h6: begin as = 1'b1; ws = 2'd2; final_pcs = 2'd2; end
      4'h7: ws = 2'd3;
      default: ;
    endcase
    is_mem = (op == 4'h2) || (op == 4'h3);

    for (int i = 0; i < iw; i++) begin
      e = '0; e.req = 1'b1;
      cycle(1'b0, rb(), rb(), rw16(), e, "fetch_wait");
    end
    e = '0; e.req = 1'b1; e.irw = 1'b1;
    cycle(1'b1, rb(), rb(), rw16(), e, "fetch");

    e = '0;
    if (op >= 4'h8 && op <= 4'hE) begin
      e.ill = 1'b1; e.pw = 1'b1;
      cycle(rb(), rb(), rb(), ins, e, "decode_illegal");
      return;
    end
    cycle(rb(), rb(), rb(), ins, e, "decode");
    if (op == 4'hF) return;

    e = '0; e.as = as; e.wbs = ws;
    if (op == 4'h4) begin
      e.pw = 1'b1; e.pcs = {1'b0, az};
      cycle(rb(), rb(), az, ins, e, "exec_beq");
      return;
    end
    cycle(rb(), rb(), rb(), ins, e, "exec");

    if (is_mem) begin
      e = '0; e.as = as; e.wbs = ws;
      e.mr = (op == 4'h2); e.mw = (op == 4'h3);
      for (int i = 0; i < dw; i++) begin
        if (abort && i == dw - 1) rst = 1'b1;
        cycle(rb(), 1'b0, rb(), ins, e, "mem_wait");
      end
      if (abort) begin
        rst = 1'b0;
        return;
      end
      e.pw = (op == 4'h3);
      cycle(rb(), 1'b1, rb(), ins, e, "mem_done");
      if (op == 4'h3) return;
    end

    e = '0; e.as = as; e.wbs = ws; e.rw = 1'b1; e.pw = 1'b1; e.pcs = final_pcs;
    cycle(rb(), rb(), rb(), ins, e, "wb");
  endtask

  initial begin
    exp_t e;
    logic [3:0] op;
    do_reset(2);

    // R-type right after reset, then the directed opcode scenarios.
    run_instr(16'h0000, 0, 0, 1'b0, 1'b0);
    run_instr(16'h2345, 0, 3, 1'b0, 1'b0);
    run_instr(16'h4123, 0, 0, 1'b1, 1'b0);
    run_instr(16'h4123, 0, 0, 1'b0, 1'b0);
    run_instr(16'h6abc, 0, 0, 1'b0, 1'b0);
    run_instr(16'h7f00, 0, 0, 1'b0, 1'b0);
    run_instr(16'h3111, 1, 0, 1'b0, 1'b0);
    run_instr(16'h1222, 2, 0, 1'b0, 1'b0);
    run_instr(16'h5333, 0, 0, 1'b0, 1'b0);
    run_instr(16'h9000, 0, 0, 1'b0, 1'b0);

    // HALT is terminal until reset, ignoring every input.
    run_instr(16'hF000, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      e = '0; e.hlt = 1'b1;
      cycle(rb(), rb(), rb(), rw16(), e, "halt");
    end
    do_reset(1);

    run_instr(16'h0042, 0, 0, 1'b0, 1'b0);

    // Reset while STORE waits on memory: next cycle is a clean FETCH.
    run_instr(16'h3abc, 0, 2, 1'b0, 1'b1);
    e = '0; e.req = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, rw16(), e, "post_reset_fetch");

    // Randomized instruction stream (undefined opcodes included, no HALT).
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 14));
      run_instr({op, 12'($urandom())}, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), rb(), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Multi-cycle control sequencer for the 16-bit CPU datapath. Each instruction steps through a FETCH/DECODE/EXEC/MEM/WB state machine. The block drives the select lines of the shared datapath multiplexers (ALU operand B select, 3-way next-PC select, 4-way register write-back select) and the register-file, memory and PC enables. It sits between the instruction/data memory handshakes and the datapath, and counts retired instructions.

## Interface
Parameters:
- none. Widths are fixed: 16-bit instruction; opcode is `instr[15:12]`.

Ports (one clock; `rst` is synchronous and active-high):
- `clk` in 1: system clock, rising-edge.
- `rst` in 1: synchronous active-high reset.
- `instr` in 16: current instruction-register contents (valid from DECODE onward).
- `imem_ready` in 1: instruction memory has data for the current fetch.
- `dmem_ready` in 1: data memory access complete.
- `alu_zero` in 1: ALU zero flag, sampled in EXEC.
- `imem_req` out 1: fetch request.
- `ir_write` out 1: load instruction register.
- `alu_src` out 1: ALU operand B select (0 = B_data, 1 = immediate).
- `pc_src` out 2: next-PC select (0 = PC+2, 1 = PC+imm, 2 = ALU result).
- `wb_sel` out 2: write-back select (0 = ALU, 1 = dmem, 2 = PC+2, 3 = imm<<8).
- `reg_write` out 1: register-file write enable.
- `mem_read` out 1: data memory read strobe.
- `mem_write` out 1: data memory write strobe.
- `pc_write` out 1: PC update enable.
- `illegal_op` out 1: one-cycle pulse on an undefined opcode.
- `halted` out 1: core is in HALT.
- `instret` out 16: retired-instruction counter.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: `imem_req` = 1.
  - `imem_ready` = 0: stay in FETCH.
  - `imem_ready` = 1: `ir_write` = 1 this cycle, go to DECODE.
- DECODE: one cycle, then go to EXEC, except:
  - HALT (0xF): go to HALT.
  - Undefined opcode (0x8–0xE): `illegal_op` = 1, `pc_write` = 1 with `pc_src` = 0, go to FETCH. Counts as retired.
- Opcode decode and final (retiring) state:
  - 0x0 R-type: `alu_src` = 0, `wb_sel` = 0. EXEC→WB.
  - 0x1 ALU-imm: `alu_src` = 1, `wb_sel` = 0. EXEC→WB.
  - 0x2 LOAD: `alu_src` = 1, `wb_sel` = 1. EXEC→MEM→WB.
  - 0x3 STORE: `alu_src` = 1. EXEC→MEM; retires in MEM.
  - 0x4 BEQ: `alu_src` = 0. Retires in EXEC. `pc_src` = 1 if `alu_zero`, else 0.
  - 0x5 JAL: `wb_sel` = 2, `pc_src` = 1. EXEC→WB.
  - 0x6 JALR: `alu_src` = 1, `wb_sel` = 2, `pc_src` = 2. EXEC→WB.
  - 0x7 LUI: `wb_sel` = 3. EXEC→WB.
- MEM:
  - `mem_read` (LOAD) or `mem_write` (STORE) is held high until `dmem_ready`.
  - On `dmem_ready`: LOAD goes to WB; STORE retires and goes to FETCH.
- WB: `reg_write` = 1 for exactly one cycle, then go to FETCH.
- Retirement: in the retiring cycle `pc_write` = 1 exactly once per instruction, and `instret` increments by 1 (wraps 0xFFFF→0x0000).
- `pc_src` defaults to 0 in every non-retiring cycle. JAL/JALR: `pc_src` is also held in WB alongside `pc_write`, so PC+2 is written back before the PC update.
- `alu_src`/`wb_sel` are held stable from EXEC through the final state of the instruction; 0 elsewhere.
- HALT: terminal. `halted` = 1, all strobes 0. Left only via `rst`.

## Timing
- Reset (`rst` high at a clock edge):
  - Next state is FETCH and `instret` = 0.
  - All outputs go to 0 except `imem_req`, which is 1 in the first FETCH cycle after reset.
  - Reset applies from any state, including mid-MEM wait. No memory strobe survives the reset edge.
- Outputs are Moore-decoded from state plus registered opcode, except these, which are combinational from their inputs in the same cycle:
  - `ir_write` (from `imem_ready`)
  - the BEQ `pc_src` (from `alu_zero`)
  - retirement in MEM for STORE (from `dmem_ready`)
- Minimum cycles with zero-wait memories:
  - R/I/LUI/JAL/JALR: 4.
  - BEQ: 3.
  - STORE: 4.
  - LOAD: 5.
  - Each memory wait cycle adds 1.
- `imem_ready` seen outside FETCH and `dmem_ready` seen outside MEM are ignored.
- `instret` updates on the clock edge ending the retiring cycle.

## Test plan
- Reset behaviour: `rst` for 2 cycles, with `imem_ready` = 1 and `instr` = 0x0000 (R-type) after release.
  - FETCH/DECODE/EXEC/WB take 4 cycles.
  - `reg_write` and `pc_write` each pulse once in WB, with `wb_sel` = 0 and `pc_src` = 0.
  - `instret` = 1.
- LOAD with memory wait: `instr` = 0x2xxx, `dmem_ready` low for 3 MEM cycles.
  - `mem_read` is high for exactly 4 cycles; WB follows with `wb_sel` = 1.
  - Total 8 cycles.
- BEQ: `instr` = 0x4xxx.
  - With `alu_zero` = 1: `pc_src` = 1 and `pc_write` = 1 in EXEC, 3 cycles total, no `reg_write`.
  - Repeated with `alu_zero` = 0: `pc_src` = 0.
- JALR then LUI:
  - JALR: WB shows `wb_sel` = 2, `pc_src` = 2, `alu_src` = 1.
  - LUI: `wb_sel` = 3.
  - `instret` advances by 2.
- Illegal opcode and HALT:
  - 0x9000: `illegal_op` pulses one cycle in DECODE with `pc_write` = 1.
  - Then 0xF000: `halted` stays 1 for 20 cycles with no strobes; `rst` returns the core to FETCH with `instret` = 0.
- Reset mid-STORE: assert `rst` while in MEM with `dmem_ready` = 0.
  - `mem_write` is 0 on the next cycle, state is FETCH, and `instret` is cleared.
